// File: rtl/block_store_pkg.sv
// Shared types and widths for the block store: FSM state encoding plus block and address sizes.
package block_store_pkg;

  localparam int BLOCK_W = 256;
  localparam int BADDR_W = 27;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_D,
    READ_I,
    DONE
  } state_e;

endpackage

// File: rtl/block_store_wbuf.sv
// One-entry posted write buffer for block_store; only exists when BLOCK_STORE_WBUF_EN is defined.
// Capture fills the entry and acknowledges on the following cycle; drain empties it.
`ifdef BLOCK_STORE_WBUF_EN
module block_store_wbuf
  import block_store_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               capture_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [BLOCK_W-1:0] data_i,
  input  logic               drain_i,
  output logic               valid_o,
  output logic               ack_o,
  output logic [AW-1:0]      addr_o,
  output logic [BLOCK_W-1:0] data_o
);

  logic               valid_q, valid_d;
  logic               ack_q;
  logic [AW-1:0]      addr_q;
  logic [BLOCK_W-1:0] data_q;

  always_comb begin
    valid_d = valid_q;
    if (capture_i) begin
      valid_d = 1'b1;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ack_q   <= capture_i;
      if (capture_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign ack_o   = ack_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule
`endif

// File: rtl/block_store.sv
// Block store: BLOCKS x 256-bit array shared by a write-back port and data/instruction fill ports
// through one arbitrated FSM. Define BLOCK_STORE_WBUF_EN to add a one-entry posted write buffer.
module block_store
  import block_store_pkg::*;
#(
  parameter int BLOCKS  = 64,
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_req,
  input  logic [BADDR_W-1:0] wr_addr,
  input  logic [BLOCK_W-1:0] wr_data,
  output logic               wr_ack,
  input  logic               rd_req,
  input  logic [BADDR_W-1:0] rd_addr,
  output logic [BLOCK_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               if_req,
  input  logic [BADDR_W-1:0] if_addr,
  output logic [BLOCK_W-1:0] if_data,
  output logic               if_valid,
  output logic               busy
);

  localparam int IDX_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               port_i_q, port_i_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0] rd_data_q, rd_data_d;
  logic [BLOCK_W-1:0] if_data_q, if_data_d;
  logic [BLOCK_W-1:0] mem [BLOCKS];

  logic               last_c, arb_c, mem_we;
  logic               want_w, want_d, want_i;
  logic               pick_w, pick_d, pick_i;
  logic [IDX_W-1:0]   w_idx;
  logic [BLOCK_W-1:0] w_data, rd_word;
  logic               unused_addr_bits;

  assign last_c = (cnt_q == '0);
  assign mem_we = (state_q == WRITE) && last_c;
  // Arbitration happens in IDLE, DONE and the last WRITE cycle so back-to-back work never idles.
  assign arb_c  = (state_q == IDLE) || (state_q == DONE) || mem_we;
  // The port that just completed still holds its request this cycle, so it is masked out.
  assign want_d = rd_req && !((state_q == DONE) && !port_i_q);
  assign want_i = if_req && !((state_q == DONE) && port_i_q);
  assign unused_addr_bits = ^{wr_addr[BADDR_W-1:IDX_W], rd_addr[BADDR_W-1:IDX_W],
                              if_addr[BADDR_W-1:IDX_W]};

`ifdef BLOCK_STORE_WBUF_EN
  logic               wb_valid, wb_ack, wb_capture;
  logic [IDX_W-1:0]   wb_idx;
  logic [BLOCK_W-1:0] wb_data;

  assign wb_capture = wr_req && !wb_valid && !wb_ack &&
                      (state_q inside {IDLE, READ_D, READ_I});

  block_store_wbuf #(.AW(IDX_W)) u_wbuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture_i (wb_capture),
    .addr_i    (wr_addr[IDX_W-1:0]),
    .data_i    (wr_data),
    .drain_i   (mem_we),
    .valid_o   (wb_valid),
    .ack_o     (wb_ack),
    .addr_o    (wb_idx),
    .data_o    (wb_data)
  );

  // Posted data drains only when neither fill port is waiting.
  assign want_w  = wb_valid && (state_q != WRITE);
  assign pick_d  = want_d;
  assign pick_i  = want_i && !want_d;
  assign pick_w  = want_w && !want_d && !want_i;
  assign w_idx   = wb_idx;
  assign w_data  = wb_data;
  assign rd_word = (wb_valid && (wb_idx == idx_q)) ? wb_data : mem[idx_q];
  assign wr_ack  = wb_ack;
`else
  logic [BLOCK_W-1:0] wdata_q;

  assign want_w  = wr_req && (state_q != WRITE);
  assign pick_w  = want_w;
  assign pick_d  = want_d && !want_w;
  assign pick_i  = want_i && !want_w && !want_d;
  assign w_idx   = wr_addr[IDX_W-1:0];
  assign w_data  = wdata_q;
  assign rd_word = mem[idx_q];
  assign wr_ack  = mem_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdata_q <= '0;
    end else if (arb_c && pick_w) begin
      wdata_q <= wr_data;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_i_d  = port_i_q;
    idx_d     = idx_q;
    rd_data_d = rd_data_q;
    if_data_d = if_data_q;
    if ((state_q inside {WRITE, READ_D, READ_I}) && !last_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if ((state_q == READ_D) && last_c) begin
      rd_data_d = rd_word;
      state_d   = DONE;
    end
    if ((state_q == READ_I) && last_c) begin
      if_data_d = rd_word;
      state_d   = DONE;
    end
    if (arb_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (pick_w) begin
        state_d = WRITE;
        cnt_d   = CNT_LOAD;
        idx_d   = w_idx;
      end else if (pick_d) begin
        state_d  = READ_D;
        cnt_d    = CNT_LOAD;
        idx_d    = rd_addr[IDX_W-1:0];
        port_i_d = 1'b0;
      end else if (pick_i) begin
        state_d  = READ_I;
        cnt_d    = CNT_LOAD;
        idx_d    = if_addr[IDX_W-1:0];
        port_i_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      port_i_q  <= 1'b0;
      idx_q     <= '0;
      rd_data_q <= '0;
      if_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_i_q  <= port_i_d;
      idx_q     <= idx_d;
      rd_data_q <= rd_data_d;
      if_data_q <= if_data_d;
    end
  end

  // Array is never reset; a write interrupted by reset never reaches its commit cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= w_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign if_data  = if_data_q;
  assign rd_valid = (state_q == DONE) && !port_i_q;
  assign if_valid = (state_q == DONE) && port_i_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_block_store.sv
// Bench for block_store: directed port transactions, a transaction-scheduling reference model
// compared every cycle, and literal latency/data expectations. Covers BLOCK_STORE_WBUF_EN too.
module tb_block_store;
  import block_store_pkg::*;

  localparam int L = 3;
  localparam int B = 64;
  localparam logic [255:0] PX  = {8{32'h1357_9BDF}};
  localparam logic [255:0] PY  = {8{32'h2468_ACE0}};
  localparam logic [255:0] PZ  = {8{32'hFEED_F00D}};
  localparam logic [255:0] PA5 = {32{8'hA5}};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         wr_req = 1'b0, rd_req = 1'b0, if_req = 1'b0;
  logic [26:0]  wr_addr = '0, rd_addr = '0, if_addr = '0;
  logic [255:0] wr_data = '0;
  logic         wr_ack, rd_valid, if_valid, busy;
  logic [255:0] rd_data, if_data;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  block_store #(.BLOCKS(B), .LATENCY(L)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_data  (if_data),
    .if_valid (if_valid),
    .busy     (busy)
  );

  function automatic logic [255:0] pat(input int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drivers: called at posedge+1; k is the cycle offset of the ack/valid pulse from the request.
  task automatic do_write(input logic [26:0] a, input logic [255:0] d, output int k);
    wr_req = 1'b1; wr_addr = a; wr_data = d; k = 0;
    forever begin
      @(negedge clk);
      if (wr_ack) break;
      k++;
      if (k > 100) begin
        chk("wr_ack_timeout", wr_ack, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic do_read(input bit side, input logic [26:0] a, output logic [255:0] d,
                         output int k);
    if (side) begin if_req = 1'b1; if_addr = a; end
    else begin rd_req = 1'b1; rd_addr = a; end
    k = 0; d = '0;
    forever begin
      @(negedge clk);
      if (side ? if_valid : rd_valid) begin
        d = side ? if_data : rd_data;
        break;
      end
      k++;
      if (k > 100) begin
        chk("valid_timeout", side ? if_valid : rd_valid, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    if (side) if_req = 1'b0; else rd_req = 1'b0;
  endtask

  // Reference model: a single server granting the highest-priority waiting port whenever it is
  // free. A write occupies it L cycles (ack in the last); a read L cycles plus one for the pulse.
  int           cyc = 0;
  int           job_kind = 0, job_start = 0, job_end = -1, job_idx = 0;
  int           dec_cyc = 0, mask_kind = 0;
  logic [255:0] job_data = '0;
  bit           job_known = 1'b0;
  logic [255:0] mdl_mem [B];
  bit           mdl_known [B];
  logic [255:0] exp_rd = '0, exp_if = '0;
  bit           rd_known = 1'b1, if_known = 1'b1;

  initial begin
    bit e_busy, e_ack, e_rv, e_iv;
    int m, dur, ix;
    for (int i = 0; i < B; i++) mdl_known[i] = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        chk("rst_wr_ack", wr_ack, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_if_data", if_data, '0);
        job_kind = 0; job_end = -1; dec_cyc = 0; mask_kind = 0;
        exp_rd = '0; exp_if = '0; rd_known = 1'b1; if_known = 1'b1;
      end else begin
`ifndef BLOCK_STORE_WBUF_EN
        e_busy = (job_kind != 0) && (cyc > job_start) && (cyc <= job_end);
        e_ack  = (job_kind == 1) && (cyc == job_end);
        e_rv   = (job_kind == 2) && (cyc == job_end);
        e_iv   = (job_kind == 3) && (cyc == job_end);
        if (e_rv) begin exp_rd = job_data; rd_known = job_known; end
        if (e_iv) begin exp_if = job_data; if_known = job_known; end
        chk("busy", busy, e_busy);
        chk("wr_ack", wr_ack, e_ack);
        chk("rd_valid", rd_valid, e_rv);
        chk("if_valid", if_valid, e_iv);
        if (rd_known) chk("rd_data", rd_data, exp_rd);
        if (if_known) chk("if_data", if_data, exp_if);
        if (e_ack) begin
          mdl_mem[job_idx] = job_data;
          mdl_known[job_idx] = 1'b1;
        end
        if (cyc >= dec_cyc) begin
          m = (cyc == dec_cyc) ? mask_kind : 0;
          dur = 0;
          if (wr_req && m != 1) begin
            job_kind = 1; job_idx = int'(wr_addr) % B; job_data = wr_data;
            job_known = 1'b1; dur = L;
          end else if (rd_req && m != 2) begin
            ix = int'(rd_addr) % B;
            job_kind = 2; job_data = mdl_mem[ix]; job_known = mdl_known[ix]; dur = L + 1;
          end else if (if_req && m != 3) begin
            ix = int'(if_addr) % B;
            job_kind = 3; job_data = mdl_mem[ix]; job_known = mdl_known[ix]; dur = L + 1;
          end
          if (dur > 0) begin
            job_start = cyc; job_end = cyc + dur; dec_cyc = job_end; mask_kind = job_kind;
          end else begin
            dec_cyc = cyc + 1; mask_kind = 0;
          end
        end
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, kw, kr, ki, k2;
    bit got;
    logic [255:0] d, d1, d2;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
`ifdef BLOCK_STORE_WBUF_EN
    fork
      begin
        do_write(27'd9, pat(9), kw);
        do_write(27'd10, pat(10), k2);
      end
      begin
        @(posedge clk); #1;
        do_read(1'b0, 27'd9, d1, kr);
      end
    join
    chk("posted_ack_cycle", kw, 1);
    chk("posted_read_data", d1, pat(9));
    chk("second_write_waits_drain", k2, 8);
    do_read(1'b0, 27'd10, d, k);
    chk("second_write_data", d, pat(10));
    do_read(1'b1, 27'd73, d, k);
    chk("drained_block_data", d, pat(9));
`else
    for (int i = 0; i < 8; i++) begin
      do_write(27'(i), pat(i), k);
      chk("wr_ack_latency", k, L);
    end
    do_read(1'b1, 27'd2, d, k);
    chk("if_fill_latency", k, L + 1);
    chk("if_fill_data", d, pat(2));

    fork
      do_write(27'd3, PX, kw);
      do_read(1'b0, 27'd3, d1, kr);
    join
    chk("wr_rd_same_ack_cycle", kw, 3);
    chk("wr_rd_same_valid_cycle", kr, 7);
    chk("wr_rd_same_data", d1, PX);

    fork
      do_read(1'b0, 27'd1, d1, kr);
      do_read(1'b1, 27'd2, d2, ki);
    join
    chk("rd_first_cycle", kr, L + 1);
    chk("if_after_rd_gap", ki - kr, L + 1);
    chk("rd_first_data", d1, pat(1));
    chk("if_second_data", d2, pat(2));

    do_read(1'b0, 27'd71, d, k);
    chk("addr_wrap_71", d, pat(7));
    do_read(1'b1, 27'h7FF_FFC7, d, k);
    chk("addr_upper_ignored", d, pat(7));
    do_write(27'd70, PY, k);
    do_read(1'b0, 27'd6, d, k);
    chk("wr_wrap_70_to_6", d, PY);

    fork
      do_write(27'd6, PZ, kw);
      do_read(1'b1, 27'd6, d2, ki);
    join
    chk("wr_if_same_valid_cycle", ki, 7);
    chk("wr_if_same_data", d2, PZ);

    rd_addr = 27'd4; rd_req = 1'b1;
    @(posedge clk); #1 rd_req = 1'b0;
    got = 1'b0; d = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rd_valid) begin got = 1'b1; d = rd_data; end
    end
    chk("dropped_rd_completes", got, 1'b1);
    chk("dropped_rd_data", d, pat(4));
    @(posedge clk); #1;

    wr_addr = 27'd5; wr_data = PA5; wr_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    chk("mid_write_rst_busy", busy, 1'b0);
    chk("mid_write_rst_ack", wr_ack, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    do_read(1'b0, 27'd5, d, k);
    chk("rst_mid_write_keeps_block", d, pat(5));
    chk("rst_mid_write_not_a5", d == PA5, 1'b0);
`endif
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/block_store.md
BLOCK_STORE -- requirements
Module: block_store

Interface
REQ-001 SHALL have parameter BLOCKS, default 64, meaning number of 256-bit blocks held (power of two).
REQ-002 SHALL have parameter LATENCY, default 3, meaning array access cycles per transaction (>=1).
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named clk and reset_n.
REQ-004 Port list:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  async active-low reset
- wr_req  input  1  write-back request, held until wr_ack
- wr_addr  input  27  block address of write-back
- wr_data  input  256  block to write
- wr_ack  output  1  one-cycle pulse, write accepted/committed
- rd_req  input  1  data-side block fill request, held until rd_valid
- rd_addr  input  27  data-side block address
- rd_data  output  256  data-side block, valid with rd_valid
- rd_valid  output  1  one-cycle pulse
- if_req  input  1  instruction-side fill request, held until if_valid
- if_addr  input  27  instruction-side block address
- if_data  output  256  instruction-side block, valid with if_valid
- if_valid  output  1  one-cycle pulse
- busy  output  1  high while any transaction is accepted and not completed

Function
REQ-005 SHALL index the array with addr modulo BLOCKS (low log2(BLOCKS) bits); upper bits ignored.
REQ-006 SHALL implement FSM states IDLE, WRITE, READ_D, READ_I, DONE.
REQ-007 In IDLE, SHALL select by fixed priority wr_req > rd_req > if_req; no request -> stay IDLE.
REQ-008 Each of WRITE/READ_D/READ_I SHALL last exactly LATENCY cycles, counted by a down-counter loaded with LATENCY-1.
REQ-009 Write SHALL commit to the array only on the last WRITE cycle; wr_ack pulses that same cycle.
REQ-010 rd_valid/if_valid SHALL pulse on the cycle after the last READ_x cycle (DONE); rd_data/if_data hold their value until the next completion on that port.
REQ-011 DONE SHALL last one cycle then return to IDLE; pending requests are re-arbitrated there.
REQ-012 busy SHALL be high from the cycle after a request is accepted through the DONE/last-WRITE cycle inclusive.
REQ-013 Simultaneous wr_req and rd_req to the same block SHALL yield rd_data equal to wr_data (write serviced first).
REQ-014 A request dropped before completion SHALL still complete; its valid/ack pulse is emitted.

Reset
REQ-015 reset_n low SHALL force IDLE, counter 0, wr_ack/rd_valid/if_valid/busy 0, rd_data/if_data 0, write buffer invalid.
REQ-016 Array contents SHALL be unaffected by reset; reset during WRITE SHALL leave the target block unmodified.

Configuration
REQ-017 Macro BLOCK_STORE_WBUF_EN SHALL enable a one-entry posted write buffer.
REQ-018 With macro: wr_req in IDLE or READ_x with buffer empty -> captured, wr_ack next cycle; drained via WRITE only when no read pending; write with buffer full waits for drain.
REQ-019 With macro: read of the buffered block address SHALL return buffer contents after LATENCY cycles, ignoring the stale array.
REQ-020 Without macro: writes take the FSM path of REQ-009; no buffer logic synthesised.

Structure
REQ-021 Shared package block_store_pkg SHALL hold the FSM state enum, BLOCK_W=256 and BADDR_W=27 constants.
REQ-022 Posted write buffer SHALL be a sub-module block_store_wbuf, instantiated only under BLOCK_STORE_WBUF_EN.

Verification
REQ-023 Reset mid-WRITE of block 5 (pattern A5..A5) -> later read of block 5 returns prior contents; all outputs 0 during reset.
REQ-024 wr_req addr 3 data X, then rd_req addr 3, LATENCY=3 -> wr_ack at cycle 3, rd_valid at cycle 7 with X.
REQ-025 rd_req and if_req same cycle (addr 1, 2) -> rd_valid first, if_valid LATENCY+1 cycles later; busy continuous high.
REQ-026 rd_addr 64+7 with BLOCKS=64 -> returns block 7.
REQ-027 With BLOCK_STORE_WBUF_EN: write addr 9 then immediate read addr 9 -> wr_ack next cycle, rd_data equals written block; second write stalls until drain.
